// File: rtl/perm_pkg.sv
// Shared types and helpers for the runtime-programmable bit-permutation engine.
// Optional feature macro (used by perm_engine): PERM_INVERSE_EN.
package perm_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_CHECK,
    ST_SWAP
  } perm_state_e;

  // Table entry width; a 2-bit word still needs one index bit.
  function automatic int idx_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  // Entry i of the identity table routes input bit i straight to output bit i.
  function automatic int identity_entry(input int i);
    return i;
  endfunction

endpackage

// File: rtl/perm_check.sv
// Bijection checker: walks the shadow table one entry per cycle, marking which
// source bits are used and flagging out-of-range entries.
module perm_check
  import perm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [IDX_W-1:0] entry,
  output logic [IDX_W-1:0] cnt,
  output logic             last,
  output logic             ok
);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] seen_q, seen_d;
  logic             fail_q, fail_d;

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    fail_d = fail_q;
    if (start) begin
      cnt_d  = '0;
      seen_d = '0;
      fail_d = 1'b0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (int'(entry) < WIDTH) begin
        seen_d[entry] = 1'b1;
      end else begin
        fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seen_q <= '0;
      fail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      fail_q <= fail_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (int'(cnt_q) == WIDTH - 1);
  // A WIDTH-entry table that touches every source bit exactly covers it, so it is a bijection.
  assign ok   = (&seen_q) & ~fail_q;

endmodule

// File: rtl/perm_engine.sv
// Runtime-programmable bit-permutation engine with shadow/active tables and a
// one-register valid/ready datapath. Define PERM_INVERSE_EN for per-beat inverse mapping.
module perm_engine
  import perm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             wClk,
  input  logic             wRstN,
  input  logic             wInValid,
  output logic             wInReady,
  input  logic [WIDTH-1:0] wInData,
`ifdef PERM_INVERSE_EN
  input  logic             wInverse,
`endif
  output logic             wOutValid,
  input  logic             wOutReady,
  output logic [WIDTH-1:0] wOutData,
  input  logic             wCfgValid,
  input  logic [IDX_W-1:0] wCfgIdx,
  input  logic [IDX_W-1:0] wCfgSel,
  input  logic             wCfgCommit,
  output logic             wCfgBusy,
  output logic             wCfgErr
);

  perm_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] shadow_q [WIDTH];
  logic [IDX_W-1:0] shadow_d [WIDTH];
  logic [IDX_W-1:0] active_q [WIDTH];
  logic [IDX_W-1:0] active_d [WIDTH];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             chk_start, chk_step, chk_last, chk_ok;
  logic [IDX_W-1:0] chk_cnt;
  logic             swap_en;
  logic             cfg_write;
  logic             accept;
  logic [WIDTH-1:0] perm_data;

  perm_check #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_check (
    .clk  (wClk),
    .rst_n(wRstN),
    .start(chk_start),
    .step (chk_step),
    .entry(shadow_q[chk_cnt]),
    .cnt  (chk_cnt),
    .last (chk_last),
    .ok   (chk_ok)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    err_d     = err_q;
    chk_start = 1'b0;
    chk_step  = 1'b0;
    swap_en   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wCfgCommit) begin
          state_d   = ST_CHECK;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          chk_start = 1'b1;
        end
      end
      ST_CHECK: begin
        chk_step = 1'b1;
        if (chk_last) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
        if (chk_ok) begin
          swap_en = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      state_q <= ST_RUN;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // A write issued together with a commit lands before the first CHECK cycle reads the table.
  assign cfg_write = (state_q == ST_RUN) && wCfgValid && (int'(wCfgIdx) < WIDTH);

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_write) begin
      shadow_d[wCfgIdx] = wCfgSel;
    end
    if (swap_en) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      for (int i = 0; i < WIDTH; i++) begin
        shadow_q[i] <= IDX_W'(identity_entry(i));
        active_q[i] <= IDX_W'(identity_entry(i));
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    perm_data = '0;
`ifdef PERM_INVERSE_EN
    if (wInverse) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (int'(active_q[i]) < WIDTH) begin
          perm_data[active_q[i]] = wInData[i];
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        perm_data[i] = wInData[active_q[i]];
      end
    end
`else
    for (int i = 0; i < WIDTH; i++) begin
      perm_data[i] = wInData[active_q[i]];
    end
`endif
  end

  assign wInReady = ~out_valid_q | wOutReady;
  assign accept   = wInValid & wInReady;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = perm_data;
    end else if (wOutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign wOutValid = out_valid_q;
  assign wOutData  = out_data_q;
  assign wCfgBusy  = busy_q;
  assign wCfgErr   = err_q;

endmodule

// File: tb/tb_perm_engine.sv
// Directed-vector bench for perm_engine: identity, DES P-box, inverse (with
// PERM_INVERSE_EN), rejected tables, backpressure and reset during a check.
module tb_perm_engine;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;
  localparam int BUSY_CYCLES = WIDTH + 1;

  logic             wClk = 1'b0;
  logic             wRstN = 1'b0;
  logic             wInValid = 1'b0;
  logic             wInReady;
  logic [WIDTH-1:0] wInData = '0;
`ifdef PERM_INVERSE_EN
  logic             wInverse = 1'b0;
`endif
  logic             wOutValid;
  logic             wOutReady = 1'b1;
  logic [WIDTH-1:0] wOutData;
  logic             wCfgValid = 1'b0;
  logic [IDX_W-1:0] wCfgIdx = '0;
  logic [IDX_W-1:0] wCfgSel = '0;
  logic             wCfgCommit = 1'b0;
  logic             wCfgBusy;
  logic             wCfgErr;

  perm_engine #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) dut (
    .wClk      (wClk),
    .wRstN     (wRstN),
    .wInValid  (wInValid),
    .wInReady  (wInReady),
    .wInData   (wInData),
`ifdef PERM_INVERSE_EN
    .wInverse  (wInverse),
`endif
    .wOutValid (wOutValid),
    .wOutReady (wOutReady),
    .wOutData  (wOutData),
    .wCfgValid (wCfgValid),
    .wCfgIdx   (wCfgIdx),
    .wCfgSel   (wCfgSel),
    .wCfgCommit(wCfgCommit),
    .wCfgBusy  (wCfgBusy),
    .wCfgErr   (wCfgErr)
  );

  always #5 wClk = ~wClk;

  typedef struct {
    int          phase;
    logic [31:0] din;
    logic        inv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // DES straight P-box, zero-based: output bit i takes input bit desP[i].
  int desP [32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                    1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checkValue({name, " valid"}, 32'(wOutValid), 32'd1);
    checkValue({name, " data"}, wOutData, exp);
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] din, input logic inv);
    int k;
    k = 0;
    wInValid = 1'b1;
    wInData  = din;
`ifdef PERM_INVERSE_EN
    wInverse = inv;
`endif
    while (!wInReady && k < 50) begin
      @(posedge wClk);
      #1;
      k++;
    end
    if (k == 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept timeout: din %h (inv %0b) never accepted", din, inv);
    end
    @(posedge wClk);
    #1;
  endtask

  task automatic runPhase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        applyStimulus(vecs[i].din, vecs[i].inv);
        checkOutput($sformatf("phase%0d vec%0d", p, i), vecs[i].exp);
      end
    end
    wInValid = 1'b0;
    @(posedge wClk);
    #1;
    checkValue($sformatf("phase%0d drain valid", p), 32'(wOutValid), 32'd0);
  endtask

  task automatic writeCfg(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] sel, input logic commit);
    @(negedge wClk);
    wCfgValid  = 1'b1;
    wCfgIdx    = idx;
    wCfgSel    = sel;
    wCfgCommit = commit;
    @(negedge wClk);
    wCfgValid  = 1'b0;
    wCfgCommit = 1'b0;
  endtask

  // Called at the negedge of the first cycle after the commit edge.
  task automatic countBusy(input string name, input logic expErr);
    int n;
    n = 0;
    while (wCfgBusy && n < 100) begin
      n++;
      @(negedge wClk);
    end
    checkValue({name, " busy cycles"}, n, BUSY_CYCLES);
    checkValue({name, " err"}, 32'(wCfgErr), 32'(expErr));
  endtask

  task automatic commitAndWait(input string name, input logic expErr);
    @(negedge wClk);
    wCfgCommit = 1'b1;
    @(negedge wClk);
    wCfgCommit = 1'b0;
    countBusy(name, expErr);
  endtask

  task automatic doReset(input string name);
    @(negedge wClk);
    wRstN    = 1'b0;
    wInValid = 1'b0;
    #1;
    checkValue({name, " busy"}, 32'(wCfgBusy), 32'd0);
    checkValue({name, " err"}, 32'(wCfgErr), 32'd0);
    checkValue({name, " out valid"}, 32'(wOutValid), 32'd0);
    checkValue({name, " out data"}, wOutData, 32'd0);
    @(negedge wClk);
    wRstN = 1'b1;
  endtask

  initial begin
    // phase 0: identity table
    vecs.push_back('{0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{0, 32'h12345678, 1'b0, 32'h12345678});
    vecs.push_back('{0, 32'h00008000, 1'b0, 32'h00008000});
    vecs.push_back('{0, 32'h00000000, 1'b0, 32'h00000000});
    // phase 1: DES P-box forward
    vecs.push_back('{1, 32'h00008000, 1'b0, 32'h00000001});
    vecs.push_back('{1, 32'h00000001, 1'b0, 32'h00000100});
    vecs.push_back('{1, 32'h80000000, 1'b0, 32'h00100000});
    vecs.push_back('{1, 32'h00000002, 1'b0, 32'h00010000});
    vecs.push_back('{1, 32'h00000003, 1'b0, 32'h00010100});
    vecs.push_back('{1, 32'h80000002, 1'b0, 32'h00110000});
    vecs.push_back('{1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF});
    // phase 2: DES P-box, forward and inverse interleaved back-to-back
    vecs.push_back('{2, 32'h00000001, 1'b1, 32'h00008000});
    vecs.push_back('{2, 32'h00008000, 1'b0, 32'h00000001});
    vecs.push_back('{2, 32'h00000100, 1'b1, 32'h00000001});
    vecs.push_back('{2, 32'h00010000, 1'b1, 32'h00000002});
    vecs.push_back('{2, 32'h00000001, 1'b0, 32'h00000100});
    // phase 3: DES table must survive a rejected commit
    vecs.push_back('{3, 32'h00008000, 1'b0, 32'h00000001});
    vecs.push_back('{3, 32'h00000001, 1'b0, 32'h00000100});
    // phase 4: identity restored after reset
    vecs.push_back('{4, 32'h00008000, 1'b0, 32'h00008000});
    vecs.push_back('{4, 32'h00000001, 1'b0, 32'h00000001});

    repeat (2) @(negedge wClk);
    checkValue("reset busy", 32'(wCfgBusy), 32'd0);
    checkValue("reset err", 32'(wCfgErr), 32'd0);
    checkValue("reset out valid", 32'(wOutValid), 32'd0);
    checkValue("reset out data", wOutData, 32'd0);
    wRstN = 1'b1;

    runPhase(0);

    // The last DES entry is written in the same cycle as the commit.
    for (int i = 0; i < 31; i++) begin
      writeCfg(IDX_W'(i), IDX_W'(desP[i]), 1'b0);
    end
    writeCfg(IDX_W'(31), IDX_W'(desP[31]), 1'b1);
    countBusy("des commit", 1'b0);
    runPhase(1);
`ifdef PERM_INVERSE_EN
    runPhase(2);
`endif

    // Backpressure: beat A held for three edges while beat B waits.
    @(negedge wClk);
    wOutReady = 1'b0;
    wInValid  = 1'b1;
    wInData   = 32'h00008000;
    @(posedge wClk);
    #1;
    checkOutput("bp A", 32'h00000001);
    wInData = 32'h00000001;
    for (int k = 0; k < 3; k++) begin
      @(negedge wClk);
      checkValue($sformatf("bp hold%0d ready", k), 32'(wInReady), 32'd0);
      checkOutput($sformatf("bp hold%0d", k), 32'h00000001);
    end
    wOutReady = 1'b1;
    @(posedge wClk);
    #1;
    checkOutput("bp B", 32'h00000100);
    wInValid = 1'b0;
    @(posedge wClk);
    #1;
    checkValue("bp no duplicate", 32'(wOutValid), 32'd0);

    // Duplicate source bit 15 leaves bit 6 uncovered.
    writeCfg(IDX_W'(1), IDX_W'(15), 1'b0);
    commitAndWait("bad commit", 1'b1);
    runPhase(3);
    checkValue("err sticky", 32'(wCfgErr), 32'd1);

    doReset("reset in run");
    runPhase(4);

    writeCfg(IDX_W'(0), IDX_W'(6), 1'b0);
    @(negedge wClk);
    wCfgCommit = 1'b1;
    @(negedge wClk);
    wCfgCommit = 1'b0;
    repeat (4) @(negedge wClk);
    checkValue("mid-check busy", 32'(wCfgBusy), 32'd1);
    doReset("reset mid-check");
    checkValue("after reset busy", 32'(wCfgBusy), 32'd0);
    runPhase(4);

    // Shadow was restored to identity, so a bare commit must pass.
    commitAndWait("bare commit", 1'b0);
    runPhase(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
